// File: rtl/crc_pkg.sv
// Shared types and the one-bit CRC update used by the serial CRC engine.
// crc_step works on a 32-bit container; callers pick the active width.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        APPEND
    } crc_state_e;

    localparam int          CRC_MAX_W        = 32;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;

    function automatic logic [31:0] crc_step(
        input logic [31:0] cur,
        input logic        bit_in,
        input logic [31:0] poly,
        input int          width
    );
        logic [4:0]  msb;
        logic        fb;
        logic [31:0] nxt;
        logic [31:0] mask;
        msb = 5'(width - 1);
        fb  = cur[msb] ^ bit_in;
        nxt = (cur << 1) ^ (fb ? poly : 32'd0);
        if (width >= CRC_MAX_W) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational one-bit CRC update (MSB-first), shared by the generate and check paths.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(32'h07)
) (
    input  logic [CRC_W-1:0] cur,
    input  logic             bit_in,
    output logic [CRC_W-1:0] nxt
);

    assign nxt = CRC_W'(crc_step(32'(cur), bit_in, 32'(POLY), CRC_W));

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: passes frame bits through and either appends the CRC
// (generate mode) or compares the final register against RESIDUE (check mode).
//
// state  | meaning
// IDLE   | waiting for a frame; CRC register holds INIT
// FRAME  | accepting frame bits, CRC accumulating
// APPEND | shifting the CRC out MSB-first; input is stalled
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(32'h07),
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic data_valid,
    input  logic data_sof,
    input  logic data_last,
    input  logic chk_en,
    output logic in_ready,
    output logic dout,
    output logic dout_valid,
    output logic dout_is_crc,
    output logic crc_done,
    output logic crc_ok,
    output logic crc_err
);

    localparam logic [4:0] CNT_LAST = 5'(CRC_W - 1);

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] shift_q, shift_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             chk_q, chk_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_is_crc_q, dout_is_crc_d;
    logic             crc_done_q, crc_done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_err_q, crc_err_d;

    logic             accept;
    logic             start;
    logic             mode_cur;
    logic [CRC_W-1:0] crc_cur;
    logic [CRC_W-1:0] crc_nxt;

    assign in_ready = (state_q != APPEND);
    assign accept   = data_valid && in_ready;

    // A bit taken in IDLE starts a frame even without sof; sof always restarts.
    assign start    = data_sof || (state_q == IDLE);
    assign crc_cur  = start ? INIT : crc_q;
    assign mode_cur = start ? chk_en : chk_q;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .cur    (crc_cur),
        .bit_in (data_in),
        .nxt    (crc_nxt)
    );

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        chk_d         = chk_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        dout_is_crc_d = 1'b0;
        crc_done_d    = 1'b0;
        crc_ok_d      = 1'b0;
        crc_err_d     = 1'b0;

        case (state_q)
            IDLE, FRAME: begin
                if (accept) begin
                    dout_d       = data_in;
                    dout_valid_d = 1'b1;
                    chk_d        = mode_cur;
                    if (data_last) begin
                        crc_d = INIT;
                        if (mode_cur) begin
                            crc_done_d = 1'b1;
                            crc_ok_d   = (crc_nxt == RESIDUE);
                            crc_err_d  = (crc_nxt != RESIDUE);
                            state_d    = IDLE;
                        end else begin
                            shift_d = crc_nxt ^ XOR_OUT;
                            cnt_d   = CNT_LAST;
                            state_d = APPEND;
                        end
                    end else begin
                        crc_d   = crc_nxt;
                        state_d = FRAME;
                    end
                end
            end

            APPEND: begin
                dout_d        = shift_q[CRC_W-1];
                dout_valid_d  = 1'b1;
                dout_is_crc_d = 1'b1;
                shift_d       = shift_q << 1;
                if (cnt_q == 5'd0) begin
                    crc_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            crc_q         <= INIT;
            shift_q       <= '0;
            cnt_q         <= '0;
            chk_q         <= 1'b0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            dout_is_crc_q <= 1'b0;
            crc_done_q    <= 1'b0;
            crc_ok_q      <= 1'b0;
            crc_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            chk_q         <= chk_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_is_crc_q <= dout_is_crc_d;
            crc_done_q    <= crc_done_d;
            crc_ok_q      <= crc_ok_d;
            crc_err_q     <= crc_err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_is_crc = dout_is_crc_q;
    assign crc_done    = crc_done_q;
    assign crc_ok      = crc_ok_q;
    assign crc_err     = crc_err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench for crc_serial_engine: two instances (CRC-8/07 init 00 and
// CRC-16/1021 init FFFF) driven by directed and random frames against a CRC model.
module tb_crc_serial_engine;

    logic clk;
    logic rst_i [2];
    logic din   [2];
    logic dv    [2];
    logic sof   [2];
    logic last  [2];
    logic chk   [2];
    logic rdy   [2];
    logic dout  [2];
    logic dov   [2];
    logic dic   [2];
    logic done  [2];
    logic ok    [2];
    logic err   [2];

    int n_pass  = 0;
    int n_total = 0;

    logic             fq [$];
    longint unsigned  last_crc;
    logic             last_ok;
    logic             last_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    crc_serial_engine #(
        .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00)
    ) dut8 (
        .clk(clk), .rst(rst_i[0]), .data_in(din[0]), .data_valid(dv[0]),
        .data_sof(sof[0]), .data_last(last[0]), .chk_en(chk[0]),
        .in_ready(rdy[0]), .dout(dout[0]), .dout_valid(dov[0]),
        .dout_is_crc(dic[0]), .crc_done(done[0]), .crc_ok(ok[0]), .crc_err(err[0])
    );

    crc_serial_engine #(
        .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
    ) dut16 (
        .clk(clk), .rst(rst_i[1]), .data_in(din[1]), .data_valid(dv[1]),
        .data_sof(sof[1]), .data_last(last[1]), .chk_en(chk[1]),
        .in_ready(rdy[1]), .dout(dout[1]), .dout_valid(dov[1]),
        .dout_is_crc(dic[1]), .crc_done(done[1]), .crc_ok(ok[1]), .crc_err(err[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int w_of(input int s);
        return (s == 0) ? 8 : 16;
    endfunction

    function automatic longint unsigned poly_of(input int s);
        return (s == 0) ? 64'h07 : 64'h1021;
    endfunction

    function automatic longint unsigned init_of(input int s);
        return (s == 0) ? 64'h00 : 64'hFFFF;
    endfunction

    // Polynomial division of the bit stream, MSB first, seeded with INIT.
    function automatic longint unsigned model_crc(input int s, input int from);
        longint unsigned r;
        longint unsigned mask;
        int              w;
        logic            top;
        w    = w_of(s);
        mask = (64'd1 << w) - 64'd1;
        r    = init_of(s);
        for (int i = from; i < fq.size(); i++) begin
            top = r[w-1];
            r   = (r << 1) & mask;
            if (top ^ fq[i]) r = r ^ poly_of(s);
        end
        return r;
    endfunction

    task automatic push_bits(input longint unsigned value, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) fq.push_back(value[b]);
    endtask

    task automatic push_string(input string str);
        byte c;
        for (int i = 0; i < str.len(); i++) begin
            c = str[i];
            push_bits(64'(c), 8);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive fq as one frame into instance s and check the output stream cycle by cycle.
    task automatic run_frame(input int s, input bit chk_mode, input int sof_idx,
                             input int gap_mode, input bit junk, input int abort_at,
                             input string tag);
        int              idx;
        int              cyc;
        int              ncrc;
        int              rdy_low;
        int              w;
        bit              done_seen;
        bit              v;
        bit              acc;
        bit              acc_last;
        logic            acc_bit;
        longint unsigned crc_got;
        longint unsigned exp_reg;
        idx       = 0;
        cyc       = 0;
        ncrc      = 0;
        rdy_low   = 0;
        done_seen = 1'b0;
        crc_got   = 0;
        w         = w_of(s);
        exp_reg   = model_crc(s, (sof_idx > 0) ? sof_idx : 0);

        while (!done_seen && cyc < 2000) begin
            if (idx < fq.size()) begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2) == 0;
                    2:       v = ((cyc % 2) == 0) && !(cyc >= 20 && cyc < 25);
                    default: v = ($urandom_range(3, 0) != 0);
                endcase
                dv[s]   = v;
                din[s]  = v ? fq[idx] : 1'($urandom);
                sof[s]  = (idx == sof_idx);
                last[s] = (idx == fq.size() - 1);
                chk[s]  = chk_mode;
            end else begin
                dv[s]   = junk && !rdy[s];
                din[s]  = 1'($urandom);
                sof[s]  = junk;
                last[s] = junk;
                chk[s]  = 1'($urandom);
            end
            acc      = dv[s] && rdy[s];
            acc_bit  = din[s];
            acc_last = last[s];
            if (cyc == 0 && gap_mode == 0) check({tag, "_first_acc"}, 64'(rdy[s]), 64'd1);
            if (!rdy[s]) rdy_low++;

            @(posedge clk);
            #1;
            cyc++;

            if (acc) begin
                check({tag, "_pass"}, {61'd0, dov[s], dic[s], dout[s]}, {61'd0, 2'b10, acc_bit});
                idx++;
            end else if (dov[s] && dic[s]) begin
                crc_got = (crc_got << 1) | 64'(dout[s]);
                ncrc++;
            end else begin
                check({tag, "_quiet"}, 64'(dov[s]), 64'd0);
            end

            if (done[s]) begin
                done_seen = 1'b1;
                last_crc  = crc_got;
                last_ok   = ok[s];
                last_err  = err[s];
                if (chk_mode) begin
                    check({tag, "_done_align"}, 64'(acc && acc_last), 64'd1);
                    check({tag, "_ncrc_chk"}, 64'(ncrc), 64'd0);
                    check({tag, "_ok"}, 64'(ok[s]), 64'(exp_reg == 0));
                    check({tag, "_err"}, 64'(err[s]), 64'(exp_reg != 0));
                end else begin
                    check({tag, "_ncrc"}, 64'(ncrc), 64'(w));
                    check({tag, "_crc"}, crc_got, exp_reg);
                    check({tag, "_okerr_gen"}, {62'd0, ok[s], err[s]}, 64'd0);
                    check({tag, "_rdy_low"}, 64'(rdy_low), 64'(w));
                    check({tag, "_rdy_reentry"}, 64'(rdy[s]), 64'd1);
                end
            end else begin
                check({tag, "_nopulse"}, {62'd0, ok[s], err[s]}, 64'd0);
            end

            if (abort_at > 0 && ncrc == abort_at && !done_seen) begin
                rst_i[s] = 1'b1;
                dv[s]    = 1'b0;
                #1;
                check({tag, "_rst_rdy"}, 64'(rdy[s]), 64'd1);
                check({tag, "_rst_dov"}, 64'(dov[s]), 64'd0);
                @(posedge clk);
                #1;
                check({tag, "_rst_quiet"}, {61'd0, dov[s], dic[s], done[s]}, 64'd0);
                rst_i[s] = 1'b0;
                sof[s]   = 1'b0;
                last[s]  = 1'b0;
                return;
            end
        end
        check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
        dv[s]   = 1'b0;
        sof[s]  = 1'b0;
        last[s] = 1'b0;
    endtask

    initial begin
        int  s;
        int  len;
        int  sidx;
        bit  cm;
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1;
            din[i]   = 1'b0;
            dv[i]    = 1'b0;
            sof[i]   = 1'b0;
            last[i]  = 1'b0;
            chk[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_in_rst", {57'd0, rdy[i], dout[i], dov[i], dic[i], done[i], ok[i], err[i]},
                  64'b1000000);
            rst_i[i] = 1'b0;
        end
        idle(1);
        for (int i = 0; i < 2; i++) begin
            check("reset_after", {57'd0, rdy[i], dout[i], dov[i], dic[i], done[i], ok[i], err[i]},
                  64'b1000000);
        end

        // CRC-8 generate on the check string
        fq.delete();
        push_string("123456789");
        run_frame(0, 1'b0, 0, 0, 1'b0, 0, "t1");
        check("t1_known", last_crc, 64'hF4);
        idle(2);

        // CRC-16/CCITT generate on the check string
        run_frame(1, 1'b0, 0, 0, 1'b0, 0, "t2");
        check("t2_known", last_crc, 64'h29B1);
        idle(2);

        // check mode: good frame then last bit flipped
        push_bits(64'hF4, 8);
        run_frame(0, 1'b1, 0, 0, 1'b0, 0, "t3a");
        check("t3a_ok_known", {62'd0, last_ok, last_err}, 64'b10);
        idle(2);
        fq[fq.size() - 1] = ~fq[fq.size() - 1];
        run_frame(0, 1'b1, 0, 0, 1'b0, 0, "t3b");
        check("t3b_err_known", {62'd0, last_ok, last_err}, 64'b01);
        idle(2);

        // gapped input
        fq.delete();
        push_string("123456789");
        run_frame(0, 1'b0, 0, 2, 1'b0, 0, "t4");
        check("t4_known", last_crc, 64'hF4);
        idle(2);

        // reset during APPEND, then a clean frame
        run_frame(0, 1'b0, 0, 0, 1'b0, 3, "t5a");
        idle(1);
        run_frame(0, 1'b0, 0, 0, 1'b0, 0, "t5b");
        check("t5b_known", last_crc, 64'hF4);
        idle(2);

        // back-to-back: frame with junk valid during APPEND, then a 1-bit frame immediately
        run_frame(0, 1'b0, 0, 0, 1'b1, 0, "t6a");
        fq.delete();
        fq.push_back(1'b1);
        run_frame(0, 1'b0, 0, 0, 1'b0, 0, "t6b");
        check("t6b_known", last_crc, 64'h07);
        idle(2);

        // implicit sof and mid-frame sof restart
        fq.delete();
        push_string("123456789");
        run_frame(1, 1'b0, -1, 0, 1'b0, 0, "t7_implicit");
        check("t7_known", last_crc, 64'h29B1);
        idle(2);
        fq.delete();
        push_bits(64'hA5, 8);
        push_string("123456789");
        run_frame(0, 1'b0, 8, 0, 1'b0, 0, "t7_restart");
        check("t7r_known", last_crc, 64'hF4);
        idle(2);

        // random frames on both widths
        for (int n = 0; n < 40; n++) begin
            s   = int'($urandom_range(1, 0));
            cm  = 1'($urandom);
            len = int'($urandom_range(24, 1));
            fq.delete();
            for (int i = 0; i < len; i++) fq.push_back(1'($urandom));
            case ($urandom_range(3, 0))
                0:       sidx = -1;
                1:       sidx = (len > 1) ? int'($urandom_range(len - 1, 1)) : 0;
                default: sidx = 0;
            endcase
            if (cm && $urandom_range(2, 0) != 0) begin
                push_bits(model_crc(s, (sidx > 0) ? sidx : 0), w_of(s));
                if ($urandom_range(3, 0) == 0) begin
                    int k;
                    k = int'($urandom_range(fq.size() - 1, 0));
                    fq[k] = ~fq[k];
                end
            end
            run_frame(s, cm, sidx, 3, 1'($urandom), 0, "rnd");
            idle(int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
